alu_controller: RTL and testbench

Front-panel sequencer for the 16-bit computer's ALU/multiplier datapath. Collects an opcode byte, then operand A, then operand B from an 8-bit switch bus (data_in), one byte per button step. It then enables either the ALU or the multiplier and flags the result for display. Sits between board I/O (switches, button) and the ALU/multiplier/display blocks.

---
 rtl/alu_controller.sv | 96 +++++++++
 tb/tb_alu_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_controller.sv
// alu_controller: front-panel sequencer collecting opcode/A/B bytes and enabling ALU or multiplier; optional BUTTON_EDGE_EN
module alu_controller #(
    parameter int MUL_SEL_BIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [7:0] data_in,
    output logic       enAlu,
    output logic       enMul,
    output logic [3:0] opcode_o,
    output logic [7:0] opA_o,
    output logic [7:0] opB_o,
    output logic       disp_alu,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_OPCODE = 3'd0,
        S_OPA    = 3'd1,
        S_OPB    = 3'd2,
        S_EXEC   = 3'd3,
        S_DISP   = 3'd4
    } state_t;
    state_t     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [7:0] opa_q, opa_d, opb_q, opb_d;
    logic       mul_sel_q, mul_sel_d;
    logic       en_alu_q, en_mul_q, disp_q;
    logic       step;
`ifdef BUTTON_EDGE_EN
    logic [2:0] sync_q;
    // two-flop synchronizer plus one history flop; a step is a synchronized high-to-low fall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 3'b111;
        else        sync_q <= {sync_q[1:0], button};
    end
    assign step = sync_q[2] & ~sync_q[1];
`else
    assign step = ~button;
`endif
    // next-state and capture decode
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        mul_sel_d = mul_sel_q;
        case (state_q)
            S_OPCODE: if (step) begin
                opcode_d  = data_in[3:0];
                mul_sel_d = data_in[MUL_SEL_BIT];
                state_d   = S_OPA;
            end
            S_OPA: if (step) begin
                opa_d   = data_in;
                state_d = S_OPB;
            end
            S_OPB: if (step) begin
                opb_d   = data_in;
                state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_DISP;
            S_DISP:  state_d = step ? S_OPCODE : S_DISP;
            default: state_d = S_OPCODE;
        endcase
    end
    // state, latched operands and outputs registered from the next-state decode
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_OPCODE;
            opcode_q  <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            mul_sel_q <= 1'b0;
            en_alu_q  <= 1'b0;
            en_mul_q  <= 1'b0;
            disp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            mul_sel_q <= mul_sel_d;
            en_alu_q  <= (state_d == S_EXEC || state_d == S_DISP) && !mul_sel_d;
            en_mul_q  <= (state_d == S_EXEC || state_d == S_DISP) && mul_sel_d;
            disp_q    <= state_d == S_DISP;
        end
    end
    assign enAlu    = en_alu_q;
    assign enMul    = en_mul_q;
    assign disp_alu = disp_q;
    assign opcode_o = opcode_q;
    assign opA_o    = opa_q;
    assign opB_o    = opb_q;
    assign state    = state_q;
endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller: randomized check of alu_controller against a step-sequence reference model
module tb_alu_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       button = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       enAlu, enMul, disp_alu;
    logic [3:0] opcode_o;
    logic [7:0] opA_o, opB_o;
    logic [2:0] state;
    int n_tests = 0;
    int n_fail = 0;
    int         m_state;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    bit         m_mul;
    bit         h0, h1, h2;

    alu_controller #(.MUL_SEL_BIT(4)) dut (
        .clock(clock), .reset(reset), .button(button), .data_in(data_in),
        .enAlu(enAlu), .enMul(enMul), .opcode_o(opcode_o), .opA_o(opA_o),
        .opB_o(opB_o), .disp_alu(disp_alu), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_op = 4'h0; m_a = 8'h00; m_b = 8'h00; m_mul = 1'b0;
        h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
    endtask

    // one clock edge of the reference: a step occurs on a level-low button, or
    // (edge build) when the button level seen two edges ago was low after being high
    task automatic model_edge(input bit b, input logic [7:0] d);
        bit st;
`ifdef BUTTON_EDGE_EN
        st = !h1 && h2;
        h2 = h1; h1 = h0; h0 = b;
`else
        st = !b;
`endif
        case (m_state)
            0: if (st) begin m_op = d[3:0]; m_mul = d[4]; m_state = 1; end
            1: if (st) begin m_a = d; m_state = 2; end
            2: if (st) begin m_b = d; m_state = 3; end
            3: m_state = 4;
            4: if (st) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        bit busy;
        busy = (m_state == 3 || m_state == 4);
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".enAlu"}, 32'(enAlu), 32'(busy && !m_mul));
        check({tag, ".enMul"}, 32'(enMul), 32'(busy && m_mul));
        check({tag, ".disp"}, 32'(disp_alu), 32'(m_state == 4));
        check({tag, ".opcode"}, 32'(opcode_o), 32'(m_op));
        check({tag, ".opA"}, 32'(opA_o), 32'(m_a));
        check({tag, ".opB"}, 32'(opB_o), 32'(m_b));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".state"}, 32'(state), 0);
        check({tag, ".en"}, 32'({enAlu, enMul, disp_alu}), 0);
        check({tag, ".ops"}, {12'h0, opcode_o, opA_o, opB_o}, 0);
    endtask

    task automatic cyc(input bit b, input logic [7:0] d);
        button = b; data_in = d;
        @(posedge clock);
        model_edge(b, d);
        #1;
        check_all("cyc");
    endtask

    // reset dropped between edges must clear outputs before the next edge
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        button = 1'b1;
        check_all("rst_rel");
    endtask

    initial begin
        model_reset();
        #12 check_zero("reset");
        @(posedge clock);
        #1 reset = 1'b1;
        cyc(0, 8'h00);
`ifndef BUTTON_EDGE_EN
        check("and.s1", 32'(state), 1);
`endif
        cyc(0, 8'h33);
`ifndef BUTTON_EDGE_EN
        check("and.opA", 32'(opA_o), 32'h33);
`endif
        cyc(0, 8'hFF);
`ifndef BUTTON_EDGE_EN
        check("and.s3", 32'({state, enAlu, enMul}), 32'({3'd3, 2'b10}));
        check("and.opB", 32'(opB_o), 32'hFF);
`endif
        cyc(0, 8'h00);
`ifndef BUTTON_EDGE_EN
        check("and.disp", 32'({state, disp_alu}), 32'({3'd4, 1'b1}));
`endif
        do_reset();
        cyc(0, 8'h15);
        cyc(0, 8'hA5);
        cyc(0, 8'h5A);
`ifndef BUTTON_EDGE_EN
        check("mul.op", 32'(opcode_o), 32'h5);
        check("mul.s3", 32'({state, enAlu, enMul}), 32'({3'd3, 2'b01}));
`endif
        cyc(1, 8'h00);
`ifndef BUTTON_EDGE_EN
        check("mul.s4", 32'({state, enAlu, enMul}), 32'({3'd4, 2'b01}));
`endif
        do_reset();
        cyc(0, 8'h07);
        for (int i = 0; i < 10; i++) cyc(1, 8'($urandom));
        cyc(0, 8'h42);
        do_reset();
        cyc(0, 8'h19);
        cyc(0, 8'h81);
        cyc(0, 8'h18);
`ifdef BUTTON_EDGE_EN
        do_reset();
        cyc(1, 8'h00);
        cyc(1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 8'h23);
            check("edge.adv", 32'(state), (i >= 2) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) cyc(1, 8'h00);
        check("edge.hold", 32'(state), 1);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc($urandom_range(0, 2) != 0, 8'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
